// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS data-memory path.
package mips_pkg;

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} dmem_arb_state_t;
  typedef enum logic {OWN_CPU, OWN_DBG} dmem_owner_t;

  localparam int DMEM_ADDR_W = 5;

  // Bits needed to hold 0..max_val; never narrower than one bit.
  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/dmem_arbiter.sv
// Serializes CPU (MEM stage) and debug-port accesses onto one single-port data memory.
// CPU has priority; a starvation counter forces a debug grant after STARVE_MAX CPU wins.
module dmem_arbiter
  import mips_pkg::*;
#(
  parameter int ADDR_W     = DMEM_ADDR_W,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        cpu_m,
  input  logic [31:0]       cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_done,
  output logic              cpu_stall,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              dbg_done,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int SC_W = cnt_width(STARVE_MAX);
  localparam int LC_W = cnt_width(MEM_LAT);

  dmem_arb_state_t   r_state;
  dmem_owner_t       r_owner;
  logic              r_is_write;
  logic [SC_W-1:0]   r_starve_cnt;
  logic [LC_W-1:0]   r_lat_cnt;
  logic              r_mem_en;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic [DATA_W-1:0] r_cpu_rdata;
  logic              r_cpu_done;
  logic [DATA_W-1:0] r_dbg_rdata;
  logic              r_dbg_done;

  logic w_cpu_req;
  logic w_cpu_we;
  logic w_starved;
  logic w_grant_dbg;
  logic w_any_req;
  logic w_complete;
  logic w_unused_addr;

  assign w_cpu_req   = cpu_m[1] | cpu_m[0];
  assign w_cpu_we    = cpu_m[0];
  assign w_starved   = dbg_req & (r_starve_cnt == SC_W'(STARVE_MAX));
  assign w_grant_dbg = dbg_req & (~w_cpu_req | w_starved);
  assign w_any_req   = w_cpu_req | dbg_req;

  // Memory data is sampled on the MEM_LAT-th edge after the strobe cycle begins.
  assign w_complete  = ((r_state == ACCESS) && (MEM_LAT == 1)) ||
                       ((r_state == WAIT) && (r_lat_cnt == LC_W'(1)));

  assign w_unused_addr = ^cpu_addr[31:ADDR_W];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_owner      <= OWN_CPU;
      r_is_write   <= 1'b0;
      r_starve_cnt <= '0;
      r_lat_cnt    <= '0;
      r_mem_en     <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_cpu_rdata  <= '0;
      r_cpu_done   <= 1'b0;
      r_dbg_rdata  <= '0;
      r_dbg_done   <= 1'b0;
    end else begin
      r_cpu_done <= 1'b0;
      r_dbg_done <= 1'b0;

      case (r_state)
        IDLE: begin
          if (w_any_req) begin
            r_state     <= ACCESS;
            r_mem_en    <= 1'b1;
            r_owner     <= w_grant_dbg ? OWN_DBG : OWN_CPU;
            r_is_write  <= w_grant_dbg ? dbg_we : w_cpu_we;
            r_mem_we    <= w_grant_dbg ? dbg_we : w_cpu_we;
            r_mem_addr  <= w_grant_dbg ? dbg_addr : cpu_addr[ADDR_W-1:0];
            r_mem_wdata <= w_grant_dbg ? dbg_wdata : cpu_wdata;
          end
          if (w_grant_dbg || !dbg_req) begin
            r_starve_cnt <= '0;
          end else if (w_cpu_req && (r_starve_cnt != SC_W'(STARVE_MAX))) begin
            r_starve_cnt <= r_starve_cnt + 1'b1;
          end
        end
        ACCESS: begin
          r_mem_en  <= 1'b0;
          r_mem_we  <= 1'b0;
          r_lat_cnt <= LC_W'(MEM_LAT - 1);
          r_state   <= (MEM_LAT > 1) ? WAIT : RESP;
        end
        WAIT: begin
          r_lat_cnt <= r_lat_cnt - 1'b1;
          if (r_lat_cnt == LC_W'(1)) begin
            r_state <= RESP;
          end
        end
        RESP: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase

      // Writes return zero so the requester never sees stale bus data.
      if (w_complete) begin
        if (r_owner == OWN_CPU) begin
          r_cpu_rdata <= r_is_write ? '0 : mem_rdata;
          r_cpu_done  <= 1'b1;
        end else begin
          r_dbg_rdata <= r_is_write ? '0 : mem_rdata;
          r_dbg_done  <= 1'b1;
        end
      end
    end
  end

  assign cpu_stall = w_cpu_req & ~r_cpu_done;
  assign cpu_rdata = r_cpu_rdata;
  assign cpu_done  = r_cpu_done;
  assign dbg_rdata = r_dbg_rdata;
  assign dbg_done  = r_dbg_done;
  assign mem_en    = r_mem_en;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: one instance at MEM_LAT=1 and one at MEM_LAT=3, each with its own memory model.
module tb_dmem_arbiter;
  import mips_pkg::*;

  localparam int SMAX = 4;
  localparam logic [31:0] BAD = 32'hBAD0_BAD0;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [1:0]  a_cpu_m = '0;
  logic [31:0] a_cpu_addr = '0, a_cpu_wdata = '0, a_cpu_rdata;
  logic        a_cpu_done, a_cpu_stall;
  logic        a_dbg_req = 1'b0, a_dbg_we = 1'b0;
  logic [4:0]  a_dbg_addr = '0;
  logic [31:0] a_dbg_wdata = '0, a_dbg_rdata;
  logic        a_dbg_done, a_mem_en, a_mem_we;
  logic [4:0]  a_mem_addr;
  logic [31:0] a_mem_wdata, a_mem_rdata;

  logic [1:0]  b_cpu_m = '0;
  logic [31:0] b_cpu_addr = '0, b_cpu_wdata = '0, b_cpu_rdata;
  logic        b_cpu_done, b_cpu_stall;
  logic        b_dbg_req = 1'b0, b_dbg_we = 1'b0;
  logic [4:0]  b_dbg_addr = '0;
  logic [31:0] b_dbg_wdata = '0, b_dbg_rdata;
  logic        b_dbg_done, b_mem_en, b_mem_we;
  logic [4:0]  b_mem_addr;
  logic [31:0] b_mem_wdata, b_mem_rdata;

  dmem_arbiter #(.ADDR_W(5), .DATA_W(32), .MEM_LAT(1), .STARVE_MAX(SMAX)) u_dut_a (
    .clk(clk), .rst_n(rst_n),
    .cpu_m(a_cpu_m), .cpu_addr(a_cpu_addr), .cpu_wdata(a_cpu_wdata),
    .cpu_rdata(a_cpu_rdata), .cpu_done(a_cpu_done), .cpu_stall(a_cpu_stall),
    .dbg_req(a_dbg_req), .dbg_we(a_dbg_we), .dbg_addr(a_dbg_addr), .dbg_wdata(a_dbg_wdata),
    .dbg_rdata(a_dbg_rdata), .dbg_done(a_dbg_done),
    .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_addr(a_mem_addr),
    .mem_wdata(a_mem_wdata), .mem_rdata(a_mem_rdata)
  );

  dmem_arbiter #(.ADDR_W(5), .DATA_W(32), .MEM_LAT(3), .STARVE_MAX(SMAX)) u_dut_b (
    .clk(clk), .rst_n(rst_n),
    .cpu_m(b_cpu_m), .cpu_addr(b_cpu_addr), .cpu_wdata(b_cpu_wdata),
    .cpu_rdata(b_cpu_rdata), .cpu_done(b_cpu_done), .cpu_stall(b_cpu_stall),
    .dbg_req(b_dbg_req), .dbg_we(b_dbg_we), .dbg_addr(b_dbg_addr), .dbg_wdata(b_dbg_wdata),
    .dbg_rdata(b_dbg_rdata), .dbg_done(b_dbg_done),
    .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
    .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata)
  );

  // Memories load word i = i while reset is held. Instance a reads within the strobe cycle,
  // instance b presents data only in the cycle two after the strobe; otherwise a poison value.
  logic [31:0] mem_a [32];
  logic [31:0] mem_b [32];
  logic [4:0]  b_hold;
  int          b_cnt;

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) mem_a[i] <= 32'(i);
    end else if (a_mem_en && a_mem_we) begin
      mem_a[a_mem_addr] <= a_mem_wdata;
    end
  end
  assign a_mem_rdata = a_mem_en ? mem_a[a_mem_addr] : BAD;

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) mem_b[i] <= 32'(i);
      b_cnt  <= 0;
      b_hold <= '0;
    end else if (b_mem_en) begin
      if (b_mem_we) mem_b[b_mem_addr] <= b_mem_wdata;
      b_hold <= b_mem_addr;
      b_cnt  <= 1;
    end else if (b_cnt != 0 && b_cnt < 3) begin
      b_cnt <= b_cnt + 1;
    end else begin
      b_cnt <= 0;
    end
  end
  assign b_mem_rdata = (b_cnt == 2) ? mem_b[b_hold] : BAD;

  // Requester helpers: start from an idle cycle, hold until done, then leave one idle cycle.
  task automatic a_cpu_op(input logic [1:0] m, input logic [31:0] addr, input logic [31:0] wd,
                          output logic [31:0] rd, output int lat);
    a_cpu_m = m; a_cpu_addr = addr; a_cpu_wdata = wd;
    lat = -1; rd = '0;
    for (int i = 1; i <= 20 && lat < 0; i++) begin
      @(negedge clk);
      if (a_cpu_done) begin rd = a_cpu_rdata; lat = i; end
    end
    a_cpu_m = 2'b00;
    @(negedge clk);
  endtask

  task automatic a_dbg_op(input logic we, input logic [4:0] addr, input logic [31:0] wd,
                          output logic [31:0] rd, output int lat);
    a_dbg_req = 1'b1; a_dbg_we = we; a_dbg_addr = addr; a_dbg_wdata = wd;
    lat = -1; rd = '0;
    for (int i = 1; i <= 20 && lat < 0; i++) begin
      @(negedge clk);
      if (a_dbg_done) begin rd = a_dbg_rdata; lat = i; end
    end
    a_dbg_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    bit seen_en = 0;
    bit got;
    a_cpu_m = 2'b10; a_cpu_addr = 32'd5; a_dbg_req = 1'b1; a_dbg_we = 1'b0; a_dbg_addr = 5'd9;
    rst_n = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (a_mem_en || b_mem_en) seen_en = 1;
    end
    checks++;
    if (seen_en) begin errors++; $display("FAIL reset_mem_en: mem_en went high during reset"); end
    checks++;
    if ({a_mem_en, a_mem_we, a_mem_addr, a_mem_wdata, a_cpu_rdata, a_cpu_done, a_dbg_rdata, a_dbg_done} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: en=%0b we=%0b addr=%0d wd=%h crd=%h cdone=%0b drd=%h ddone=%0b, want all 0",
               a_mem_en, a_mem_we, a_mem_addr, a_mem_wdata, a_cpu_rdata, a_cpu_done, a_dbg_rdata, a_dbg_done);
    end
    checks++;
    if (a_cpu_stall !== 1'b1) begin errors++; $display("FAIL reset_stall: got %0b want 1", a_cpu_stall); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (a_mem_en !== 1'b1 || a_mem_addr !== 5'd5 || a_mem_we !== 1'b0) begin
      errors++;
      $display("FAIL reset_first_grant: en=%0b addr=%0d we=%0b want en=1 addr=5 we=0", a_mem_en, a_mem_addr, a_mem_we);
    end
    got = 0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      if (a_cpu_done) begin
        got = 1;
        checks++;
        if (a_cpu_rdata !== 32'd5) begin errors++; $display("FAIL reset_cpu_data: got %h want 5", a_cpu_rdata); end
      end
    end
    a_cpu_m = 2'b00;
    checks++;
    if (!got) begin errors++; $display("FAIL reset_cpu_timeout: no cpu_done"); end
    got = 0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      if (a_dbg_done) begin
        got = 1;
        checks++;
        if (a_dbg_rdata !== 32'd9) begin errors++; $display("FAIL reset_dbg_data: got %h want 9", a_dbg_rdata); end
      end
    end
    a_dbg_req = 1'b0;
    checks++;
    if (!got) begin errors++; $display("FAIL reset_dbg_timeout: no dbg_done"); end
    @(negedge clk);
    $display("reset: outputs cleared, CPU then DBG served after release");
  endtask

  task automatic test_cpu_read();
    a_cpu_m = 2'b10; a_cpu_addr = 32'd7;
    #1;
    checks++;
    if (a_cpu_stall !== 1'b1) begin errors++; $display("FAIL read_stall_c0: got %0b want 1", a_cpu_stall); end
    @(negedge clk);
    checks++;
    if (a_mem_en !== 1'b1 || a_mem_we !== 1'b0 || a_mem_addr !== 5'd7 || a_cpu_stall !== 1'b1 || a_cpu_done !== 1'b0) begin
      errors++;
      $display("FAIL read_c1: en=%0b we=%0b addr=%0d stall=%0b done=%0b want 1 0 7 1 0",
               a_mem_en, a_mem_we, a_mem_addr, a_cpu_stall, a_cpu_done);
    end
    @(negedge clk);
    checks++;
    if (a_cpu_done !== 1'b1 || a_cpu_rdata !== 32'd7 || a_cpu_stall !== 1'b0 || a_mem_en !== 1'b0) begin
      errors++;
      $display("FAIL read_c2: done=%0b rdata=%h stall=%0b en=%0b want 1 7 0 0", a_cpu_done, a_cpu_rdata, a_cpu_stall, a_mem_en);
    end
    a_cpu_m = 2'b00;
    @(negedge clk);
    checks++;
    if (a_cpu_done !== 1'b0) begin errors++; $display("FAIL read_done_pulse: done still %0b in cycle 3", a_cpu_done); end
    $display("cpu_read: addr 7 rdata %h", a_cpu_rdata);
  endtask

  task automatic test_write_read();
    logic [31:0] rd;
    int lat;
    a_cpu_op(2'b01, 32'd3, 32'hDEADBEEF, rd, lat);
    checks++;
    if (rd !== 32'd0 || lat != 2) begin errors++; $display("FAIL wr3: rdata=%h lat=%0d want 0 2", rd, lat); end
    a_cpu_op(2'b10, 32'd3, 32'h0, rd, lat);
    checks++;
    if (rd !== 32'hDEADBEEF || lat != 2) begin errors++; $display("FAIL rd3: rdata=%h lat=%0d want deadbeef 2", rd, lat); end
    a_cpu_op(2'b11, 32'd4, 32'h1234_5678, rd, lat);
    checks++;
    if (rd !== 32'd0 || lat != 2) begin errors++; $display("FAIL rw11_4: rdata=%h lat=%0d want 0 2", rd, lat); end
    a_cpu_op(2'b10, 32'd4, 32'h0, rd, lat);
    checks++;
    if (rd !== 32'h1234_5678) begin errors++; $display("FAIL rd4: rdata=%h want 12345678", rd); end
    a_dbg_op(1'b0, 5'd3, 32'h0, rd, lat);
    checks++;
    if (rd !== 32'hDEADBEEF || lat != 2) begin errors++; $display("FAIL dbg_rd3: rdata=%h lat=%0d want deadbeef 2", rd, lat); end
    $display("write_read: deadbeef@3 and m=11 write@4 visible to later reads");
  endtask

  task automatic test_fairness();
    bit exp_dbg [10];
    int s = 0;
    int got = 0;
    for (int k = 0; k < 10; k++) begin
      if (s == SMAX) begin exp_dbg[k] = 1; s = 0; end
      else begin exp_dbg[k] = 0; s = s + 1; end
    end
    a_cpu_m = 2'b10; a_cpu_addr = 32'd20; a_dbg_req = 1'b1; a_dbg_we = 1'b0; a_dbg_addr = 5'd21;
    for (int c = 0; c < 200 && got < 10; c++) begin
      @(negedge clk);
      if (a_cpu_done && a_dbg_done) begin
        checks++; errors++; got++;
        $display("FAIL fair_both_done: access %0d both done pulses", got);
      end else if (a_cpu_done || a_dbg_done) begin
        checks++;
        if (exp_dbg[got] !== a_dbg_done) begin
          errors++;
          $display("FAIL fair_order: access %0d went to %s want %s", got,
                   a_dbg_done ? "DBG" : "CPU", exp_dbg[got] ? "DBG" : "CPU");
        end
        checks++;
        if ((a_cpu_done && a_cpu_rdata !== 32'd20) || (a_dbg_done && a_dbg_rdata !== 32'd21)) begin
          errors++;
          $display("FAIL fair_data: access %0d crd=%h drd=%h", got, a_cpu_rdata, a_dbg_rdata);
        end
        got++;
      end
    end
    checks++;
    if (got < 10) begin errors++; $display("FAIL fair_timeout: %0d of 10 accesses", got); end
    a_cpu_m = 2'b00; a_dbg_req = 1'b0;
    repeat (2) @(negedge clk);
    $display("fairness: 10 accesses, DBG forced after %0d CPU grants", SMAX);
  endtask

  task automatic test_lat3();
    int lat = -1;
    int en_cnt = 0;
    bit addr_ok = 0;
    b_dbg_req = 1'b1; b_dbg_we = 1'b0; b_dbg_addr = 5'd31;
    for (int i = 1; i <= 20 && lat < 0; i++) begin
      @(negedge clk);
      if (b_mem_en) en_cnt++;
      if (b_dbg_done) lat = i;
    end
    checks++;
    if (lat != 4 || b_dbg_rdata !== 32'd31 || en_cnt != 1) begin
      errors++;
      $display("FAIL lat3_dbg31: lat=%0d rdata=%h en_cycles=%0d want 4 31 1", lat, b_dbg_rdata, en_cnt);
    end
    b_dbg_req = 1'b0;
    @(negedge clk);
    b_cpu_m = 2'b10; b_cpu_addr = 32'd33;
    lat = -1;
    for (int i = 1; i <= 20 && lat < 0; i++) begin
      @(negedge clk);
      if (b_mem_en && b_mem_addr == 5'd1) addr_ok = 1;
      if (i == 3) begin
        checks++;
        if (b_cpu_stall !== 1'b1) begin errors++; $display("FAIL lat3_stall_wait: got %0b want 1", b_cpu_stall); end
      end
      if (b_cpu_done) begin
        lat = i;
        checks++;
        if (b_cpu_stall !== 1'b0) begin errors++; $display("FAIL lat3_stall_done: got %0b want 0", b_cpu_stall); end
      end
    end
    checks++;
    if (!addr_ok || lat != 4 || b_cpu_rdata !== 32'd1) begin
      errors++;
      $display("FAIL lat3_wrap33: addr_seen=%0b lat=%0d rdata=%h want 1 4 1", addr_ok, lat, b_cpu_rdata);
    end
    b_cpu_m = 2'b00;
    @(negedge clk);
    $display("lat3: dbg@31 and cpu@33->word1 done 4 cycles after request");
  endtask

  task automatic test_reset_wait();
    int lat = -1;
    bit stray = 0;
    b_cpu_m = 2'b10; b_cpu_addr = 32'd10;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (b_mem_en !== 1'b0 || b_cpu_done !== 1'b0 || b_cpu_rdata !== 32'd0) begin
      errors++;
      $display("FAIL rstwait_now: en=%0b done=%0b rdata=%h want 0 0 0", b_mem_en, b_cpu_done, b_cpu_rdata);
    end
    repeat (2) begin
      @(negedge clk);
      if (b_cpu_done || b_mem_en) stray = 1;
    end
    rst_n = 1'b1;
    for (int i = 1; i <= 20 && lat < 0; i++) begin
      @(negedge clk);
      if (b_cpu_done) lat = i;
    end
    checks++;
    if (stray) begin errors++; $display("FAIL rstwait_stray: done or mem_en seen during reset"); end
    checks++;
    if (lat != 4 || b_cpu_rdata !== 32'd10) begin
      errors++;
      $display("FAIL rstwait_after: lat=%0d rdata=%h want 4 10", lat, b_cpu_rdata);
    end
    b_cpu_m = 2'b00;
    @(negedge clk);
    $display("reset_wait: aborted in WAIT, next read served normally");
  endtask

  task automatic test_reset_access();
    bit stray = 0;
    a_cpu_m = 2'b01; a_cpu_addr = 32'd6; a_cpu_wdata = 32'h0000_CAFE;
    @(negedge clk);
    checks++;
    if (a_mem_en !== 1'b1) begin errors++; $display("FAIL rstacc_en: got %0b want 1 before reset", a_mem_en); end
    rst_n = 1'b0;
    #1;
    checks++;
    if (a_mem_en !== 1'b0 || a_mem_we !== 1'b0) begin
      errors++;
      $display("FAIL rstacc_async: en=%0b we=%0b want 0 0", a_mem_en, a_mem_we);
    end
    a_cpu_m = 2'b00;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (a_cpu_done || a_dbg_done || a_mem_en) stray = 1;
    end
    checks++;
    if (stray) begin errors++; $display("FAIL rstacc_stray: activity after aborted write"); end
    $display("reset_access: mem_en dropped with reset, no done");
  endtask

  task automatic test_random();
    logic [31:0] exp_mem [32];
    int s = 0;
    for (int i = 0; i < 32; i++) exp_mem[i] = 32'(i);
    for (int r = 0; r < 40; r++) begin
      int cop, dop, need, served, cyc;
      bit cpu_pend, dbg_pend, first_done;
      bit order_q[$];
      logic [1:0]  cm;
      logic [31:0] caddr, cwd, dwd, exp_rd;
      logic [4:0]  daddr;
      cop = $urandom_range(0, 3);
      dop = $urandom_range(0, 2);
      if (cop == 0 && dop == 0) cop = 1;
      cm = (cop == 1) ? 2'b10 : (cop == 2) ? 2'b01 : (cop == 3) ? 2'b11 : 2'b00;
      caddr = $urandom; cwd = $urandom; dwd = $urandom; daddr = 5'($urandom_range(0, 31));
      cpu_pend = (cop != 0); dbg_pend = (dop != 0);
      // Expected grant order from the arbitration rules (1 = DBG).
      if (dbg_pend && (!cpu_pend || s == SMAX)) begin
        order_q.push_back(1); s = 0;
        if (cpu_pend) order_q.push_back(0);
      end else begin
        order_q.push_back(0);
        s = dbg_pend ? ((s < SMAX) ? s + 1 : s) : 0;
        if (dbg_pend) begin order_q.push_back(1); s = 0; end
      end
      need = order_q.size();
      a_cpu_m = cm; a_cpu_addr = caddr; a_cpu_wdata = cwd;
      a_dbg_req = dbg_pend; a_dbg_we = (dop == 2); a_dbg_addr = daddr; a_dbg_wdata = dwd;
      served = 0; first_done = 0;
      for (cyc = 1; cyc <= 30 && served < need; cyc++) begin
        @(negedge clk);
        checks++;
        if (a_cpu_stall !== (cpu_pend & ~a_cpu_done)) begin
          errors++;
          $display("FAIL rnd_stall: round %0d cyc %0d got %0b want %0b", r, cyc, a_cpu_stall, cpu_pend & ~a_cpu_done);
        end
        if (a_cpu_done || a_dbg_done) begin
          bit who;
          who = a_dbg_done;
          checks++;
          if ((a_cpu_done && a_dbg_done) || order_q.size() == 0 || order_q[0] != who) begin
            errors++;
            $display("FAIL rnd_order: round %0d cpu_done=%0b dbg_done=%0b unexpected", r, a_cpu_done, a_dbg_done);
          end
          if (order_q.size() != 0) void'(order_q.pop_front());
          if (!who) begin
            exp_rd = cm[0] ? 32'd0 : exp_mem[caddr[4:0]];
            if (cm[0]) exp_mem[caddr[4:0]] = cwd;
            checks++;
            if (a_cpu_rdata !== exp_rd) begin
              errors++;
              $display("FAIL rnd_cpu_data: round %0d m=%b addr=%h got %h want %h", r, cm, caddr, a_cpu_rdata, exp_rd);
            end
            cpu_pend = 0; a_cpu_m = 2'b00;
          end else begin
            exp_rd = (dop == 2) ? 32'd0 : exp_mem[daddr];
            if (dop == 2) exp_mem[daddr] = dwd;
            checks++;
            if (a_dbg_rdata !== exp_rd) begin
              errors++;
              $display("FAIL rnd_dbg_data: round %0d we=%0b addr=%0d got %h want %h", r, dop == 2, daddr, a_dbg_rdata, exp_rd);
            end
            dbg_pend = 0; a_dbg_req = 1'b0;
          end
          if (!first_done) begin
            first_done = 1;
            checks++;
            if (cyc != 2) begin errors++; $display("FAIL rnd_latency: round %0d first done at %0d want 2", r, cyc); end
          end
          served++;
        end
      end
      checks++;
      if (served < need) begin errors++; $display("FAIL rnd_timeout: round %0d served %0d of %0d", r, served, need); end
      a_cpu_m = 2'b00; a_dbg_req = 1'b0;
      @(negedge clk);
      $display("random round %0d: cpu_m=%b addr=%h dbg_op=%0d daddr=%0d accesses=%0d", r, cm, caddr, dop, daddr, need);
    end
  endtask

  initial begin
    test_reset();
    test_cpu_read();
    test_write_read();
    test_fairness();
    test_lat3();
    test_reset_wait();
    test_reset_access();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
